// File: rtl/dsp_pkg.sv
// Shared DSP datapath types: rounding-mode encoding and signed-range helpers
// used by the round/saturate stage.
package dsp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC   = 2'd0,
    RND_HALF_UP = 2'd1,
    RND_EVEN    = 2'd2,
    RND_ODD     = 2'd3
  } round_mode_e;

  function automatic longint signed_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint signed_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/round_sat_ch.sv
// One channel of the round/saturate pipeline: stage 1 rounds, stage 2 range-checks.
// ROUND_SAT_EN selects clamping on overflow; otherwise the result wraps.
module round_sat_ch
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 40,
  parameter int FRAC_BITS      = 16,
  parameter int DATA_WIDTH_OUT = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  round_mode_e               mode_i,
  input  logic                      s1_en_i,
  input  logic                      s2_en_i,
  input  logic [DATA_WIDTH_IN-1:0]  data_i,
  output logic [DATA_WIDTH_OUT-1:0] data_o,
  output logic                      sat_o
);

  localparam int KW = DATA_WIDTH_IN - FRAC_BITS;
  localparam int SW = KW + 1;
  localparam logic [FRAC_BITS-1:0] HALF = FRAC_BITS'(1) << (FRAC_BITS - 1);

`ifdef ROUND_SAT_EN
  localparam logic [DATA_WIDTH_OUT-1:0] OUT_MAX = DATA_WIDTH_OUT'(signed_max(DATA_WIDTH_OUT));
  localparam logic [DATA_WIDTH_OUT-1:0] OUT_MIN = DATA_WIDTH_OUT'(signed_min(DATA_WIDTH_OUT));
`endif

  logic [KW-1:0]             keep;
  logic [FRAC_BITS-1:0]      frac;
  logic                      inc;
  logic [SW-1:0]             sum_d, sum_q;
  logic [SW-DATA_WIDTH_OUT:0] upper;
  logic                      ovf;
  logic [DATA_WIDTH_OUT-1:0] data_d, data_q;
  logic                      sat_d, sat_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    keep = data_i[DATA_WIDTH_IN-1:FRAC_BITS];
    frac = data_i[FRAC_BITS-1:0];
    inc  = 1'b0;
    case (mode_i)
      RND_TRUNC:   inc = 1'b0;
      RND_HALF_UP: inc = (frac >= HALF);
      RND_EVEN:    inc = (frac > HALF) | ((frac == HALF) &  keep[0]);
      RND_ODD:     inc = (frac > HALF) | ((frac == HALF) & ~keep[0]);
      default:     inc = 1'b0;
    endcase
    // One extra bit so the rounding carry out of the top of keep survives.
    sum_d = {keep[KW-1], keep} + SW'(inc);
  end

  // In range exactly when every bit above the output sign bit copies it.
  always_comb begin
    upper = sum_q[SW-1:DATA_WIDTH_OUT-1];
    ovf   = ~((&upper) | ~(|upper));
`ifdef ROUND_SAT_EN
    data_d = ovf ? (sum_q[SW-1] ? OUT_MIN : OUT_MAX) : sum_q[DATA_WIDTH_OUT-1:0];
`else
    data_d = sum_q[DATA_WIDTH_OUT-1:0];
`endif
    sat_d  = ovf;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: datapath registers are reset too, because tdata_o/sat_o must read zero out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sum_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (s1_en_i) sum_q <= sum_d;
      if (s2_en_i) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/round_sat.sv
// Multi-channel round/saturate stage with a two-deep valid/ready pipeline.
// Define ROUND_SAT_EN to clamp on overflow; default build wraps and flags.
module round_sat
  import dsp_pkg::*;
#(
  parameter int CH_NUM         = 2,
  parameter int DATA_WIDTH_IN  = 40,
  parameter int FRAC_BITS      = 16,
  parameter int DATA_WIDTH_OUT = 16
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [1:0]                         mode_i,
  input  logic                               tvalid_i,
  output logic                               tready_o,
  input  logic [CH_NUM*DATA_WIDTH_IN-1:0]    tdata_i,
  output logic                               tvalid_o,
  input  logic                               tready_i,
  output logic [CH_NUM*DATA_WIDTH_OUT-1:0]   tdata_o,
  output logic [CH_NUM-1:0]                  sat_o
);

  round_mode_e mode;
  logic        v1_d, v1_q, v2_d, v2_q;
  logic        s1_load, s2_load;
  logic        s1_en, s2_en;

  assign mode = round_mode_e'(mode_i);

  // Stage 2 frees itself when empty or draining; stage 1 then advances behind it.
  always_comb begin
    s2_load = ~v2_q | tready_i;
    s1_load = ~v1_q | s2_load;
    v1_d    = s1_load ? tvalid_i : v1_q;
    v2_d    = s2_load ? v1_q : v2_q;
    s1_en   = s1_load & tvalid_i;
    s2_en   = s2_load & v1_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign tready_o = s1_load;
  assign tvalid_o = v2_q;

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    round_sat_ch #(
      .DATA_WIDTH_IN  (DATA_WIDTH_IN),
      .FRAC_BITS      (FRAC_BITS),
      .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
    ) u_ch (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .mode_i  (mode),
      .s1_en_i (s1_en),
      .s2_en_i (s2_en),
      .data_i  (tdata_i[ch*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
      .data_o  (tdata_o[ch*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
      .sat_o   (sat_o[ch])
    );
  end

endmodule

// File: tb/tb_round_sat.sv
// Directed and scoreboarded bench for round_sat at IN=12, FRAC=4, OUT=6, two channels.
module tb_round_sat;

  localparam int CH   = 2;
  localparam int IN   = 12;
  localparam int FRAC = 4;
  localparam int OUT  = 6;

  logic                clk_i = 1'b0;
  logic                rstn_i;
  logic [1:0]          mode_i;
  logic                tvalid_i;
  logic                tready_o;
  logic [CH*IN-1:0]    tdata_i;
  logic                tvalid_o;
  logic                tready_i;
  logic [CH*OUT-1:0]   tdata_o;
  logic [CH-1:0]       sat_o;

  int checks   = 0;
  int failures = 0;

  round_sat #(
    .CH_NUM         (CH),
    .DATA_WIDTH_IN  (IN),
    .FRAC_BITS      (FRAC),
    .DATA_WIDTH_OUT (OUT)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .mode_i   (mode_i),
    .tvalid_i (tvalid_i),
    .tready_o (tready_o),
    .tdata_i  (tdata_i),
    .tvalid_o (tvalid_o),
    .tready_i (tready_i),
    .tdata_o  (tdata_o),
    .sat_o    (sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Integer reference: floor to keep, pick increment by mode, then clamp or wrap.
  function automatic logic [6:0] model(input logic [11:0] din, input logic [1:0] mode);
    int v, keep, frac, inc, sum, res;
    logic ovf;
    logic [31:0] r;
    v    = int'($signed(din));
    frac = ((v % 16) + 16) % 16;
    keep = (v - frac) / 16;
    case (mode)
      2'd0:    inc = 0;
      2'd1:    inc = (frac >= 8) ? 1 : 0;
      2'd2:    inc = (frac > 8 || (frac == 8 && (keep & 1) != 0)) ? 1 : 0;
      default: inc = (frac > 8 || (frac == 8 && (keep & 1) == 0)) ? 1 : 0;
    endcase
    sum = keep + inc;
    ovf = (sum > 31) || (sum < -32);
`ifdef ROUND_SAT_EN
    res = ovf ? ((sum > 0) ? 31 : -32) : sum;
`else
    res = sum;
`endif
    r = res;
    return {ovf, r[5:0]};
  endfunction

  function automatic logic [13:0] beat_exp(input logic [23:0] din, input logic [1:0] mode);
    logic [6:0] m0, m1;
    m0 = model(din[11:0], mode);
    m1 = model(din[23:12], mode);
    return {m1[6], m0[6], m1[5:0], m0[5:0]};
  endfunction

  function automatic logic [23:0] lat_din(input int i);
    logic [11:0] a, b;
    a = 12'(i * 53 + 100);
    b = 12'(i * 37 - 200);
    return {b, a};
  endfunction

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] din0;
    logic [11:0] din1;
    logic [5:0]  exp0;
    logic [5:0]  exp1;
    logic [1:0]  exp_sat;
  } vec_t;

  vec_t        vecs[9];
  logic [13:0] sb[$];
  logic [13:0] saved;
  logic [13:0] exp_b;
  bit          hold_prev;
  bit          found;

  initial begin
    vecs[0] = '{2'd0, 12'h028, 12'hFD8, 6'h02, 6'h3D, 2'b00};
    vecs[1] = '{2'd1, 12'h028, 12'hFD8, 6'h03, 6'h3E, 2'b00};
    vecs[2] = '{2'd2, 12'h028, 12'hFD8, 6'h02, 6'h3E, 2'b00};
    vecs[3] = '{2'd3, 12'h028, 12'hFD8, 6'h03, 6'h3D, 2'b00};
`ifdef ROUND_SAT_EN
    vecs[4] = '{2'd1, 12'h7FF, 12'h800, 6'h1F, 6'h20, 2'b11};
    vecs[5] = '{2'd1, 12'h1F8, 12'hE07, 6'h1F, 6'h20, 2'b01};
`else
    vecs[4] = '{2'd1, 12'h7FF, 12'h800, 6'h00, 6'h00, 2'b11};
    vecs[5] = '{2'd1, 12'h1F8, 12'hE07, 6'h20, 6'h20, 2'b01};
`endif
    vecs[6] = '{2'd2, 12'h018, 12'h1F7, 6'h02, 6'h1F, 2'b00};
    vecs[7] = '{2'd3, 12'h1F8, 12'hE08, 6'h1F, 6'h21, 2'b00};
    vecs[8] = '{2'd0, 12'h000, 12'hFFF, 6'h00, 6'h3F, 2'b00};

    rstn_i = 1'b0; mode_i = 2'd0; tvalid_i = 1'b0; tdata_i = '0; tready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_tvalid_o", 32'(tvalid_o), 32'd0);
    check("rst_tdata_o",  32'(tdata_o),  32'd0);
    check("rst_sat_o",    32'(sat_o),    32'd0);
    check("rst_tready_o", 32'(tready_o), 32'd1);
    rstn_i = 1'b1;

    // Single beats through an idle pipeline.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_i); #1;
      mode_i = vecs[i].mode; tdata_i = {vecs[i].din1, vecs[i].din0};
      tvalid_i = 1'b1; tready_i = 1'b1;
      @(posedge clk_i); #1;
      tvalid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (tvalid_o) begin found = 1'b1; break; end
        @(posedge clk_i); #1;
      end
      check($sformatf("vec%0d_valid", i), 32'(found), 32'd1);
      check($sformatf("vec%0d_ch0", i), 32'(tdata_o[5:0]),  32'(vecs[i].exp0));
      check($sformatf("vec%0d_ch1", i), 32'(tdata_o[11:6]), 32'(vecs[i].exp1));
      check($sformatf("vec%0d_sat", i), 32'(sat_o),         32'(vecs[i].exp_sat));
    end

    // Back-to-back beats: two-cycle latency, no bubbles.
    @(posedge clk_i); #1;
    tready_i = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        tvalid_i = 1'b1; tdata_i = lat_din(c); mode_i = 2'(c % 4);
      end else begin
        tvalid_i = 1'b0;
      end
      @(posedge clk_i); #1;
      if (c >= 1 && c <= 16) begin
        check($sformatf("lat%0d_valid", c), 32'(tvalid_o), 32'd1);
        exp_b = beat_exp(lat_din(c - 1), 2'((c - 1) % 4));
        check($sformatf("lat%0d_data", c), 32'({sat_o, tdata_o}), 32'(exp_b));
      end else begin
        check($sformatf("lat%0d_valid", c), 32'(tvalid_o), 32'd0);
      end
    end

    // Fill both stages under backpressure, then release in one cycle.
    tready_i = 1'b0; tvalid_i = 1'b1; mode_i = 2'd1;
    tdata_i = {12'h028, 12'h018};
    @(posedge clk_i); #1;
    tdata_i = {12'h038, 12'h048};
    @(posedge clk_i); #1;
    tdata_i = {12'h058, 12'h068};
    check("full_tready_o", 32'(tready_o), 32'd0);
    check("full_tvalid_o", 32'(tvalid_o), 32'd1);
    check("full_head", 32'({sat_o, tdata_o}), 32'(beat_exp({12'h028, 12'h018}, 2'd1)));
    @(posedge clk_i); #1;
    check("stall_hold", 32'({sat_o, tdata_o}), 32'(beat_exp({12'h028, 12'h018}, 2'd1)));
    tready_i = 1'b1;
    #1;
    check("rise_tready_o", 32'(tready_o), 32'd1);
    @(posedge clk_i); #1;
    tvalid_i = 1'b0;
    check("drain_b", 32'({sat_o, tdata_o}), 32'(beat_exp({12'h038, 12'h048}, 2'd1)));
    @(posedge clk_i); #1;
    check("drain_c", 32'({sat_o, tdata_o}), 32'(beat_exp({12'h058, 12'h068}, 2'd1)));
    @(posedge clk_i); #1;
    check("drain_empty", 32'(tvalid_o), 32'd0);

    // Asynchronous reset with both stages full.
    tready_i = 1'b0; tvalid_i = 1'b1; tdata_i = {12'h123, 12'h456};
    repeat (2) @(posedge clk_i);
    #2;
    check("pre_rst_full", 32'(tvalid_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("midrst_tvalid_o", 32'(tvalid_o), 32'd0);
    check("midrst_tready_o", 32'(tready_o), 32'd1);
    check("midrst_tdata_o",  32'(tdata_o),  32'd0);
    tvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    check("postrst_tvalid_o", 32'(tvalid_o), 32'd0);
    check("postrst_tready_o", 32'(tready_o), 32'd1);

    // Random valid/ready against a scoreboard, checking stall stability.
    hold_prev = 1'b0;
    saved = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i); #1;
      if (hold_prev) begin
        check("stall_valid", 32'(tvalid_o), 32'd1);
        check("stall_data", 32'({sat_o, tdata_o}), 32'(saved));
      end
      if (c < 300) begin
        tvalid_i = 1'($urandom_range(0, 1));
        tdata_i  = 24'($urandom);
        mode_i   = 2'($urandom_range(0, 3));
        tready_i = ($urandom_range(0, 2) != 0);
      end else begin
        tvalid_i = 1'b0;
        tready_i = 1'b1;
      end
      @(negedge clk_i);
      if (tvalid_i && tready_o) sb.push_back(beat_exp(tdata_i, mode_i));
      if (tvalid_o && tready_i) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("sb_data", 32'({sat_o, tdata_o}), 32'(sb.pop_front()));
      end
      hold_prev = tvalid_o && !tready_i;
      saved = {sat_o, tdata_o};
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
